// File: rtl/hist_sweep_ctrl.sv
// rtl/hist_sweep_ctrl.sv - frame sequencer for the histogram engine: accumulate window,
// scan sweep for cumulative stretch indices, clear sweep, and idle-time host bin reads.
module hist_sweep_ctrl #(
  parameter int DW = 8,
  parameter int TW = 32,
  parameter int IW = 640,
  parameter int IH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          din_valid,
  input  logic [TW-1:0] lowCnt,
  input  logic [TW-1:0] highCnt,
  output logic          acc_en,
  output logic [DW-1:0] bin_addr,
  output logic          bin_wr,
  input  logic [TW-1:0] bin_q,
  input  logic          host_req,
  input  logic [DW-1:0] host_addr,
  output logic          host_gnt,
  output logic [TW-1:0] host_q,
  output logic          host_qv,
  output logic [DW-1:0] lowIndex,
  output logic [DW-1:0] highIndex,
  output logic          busy,
  output logic          overrun,
  output logic          int_flag
);

  localparam int NB = 1 << DW;
  localparam int LW = $clog2(IH + 1);
  localparam int SW = DW + 1;
  localparam logic [TW:0] TOTAL = (TW+1)'(IW * IH);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SCAN, S_CLEAR, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          vsync_q, din_valid_q, qv_q, host_qv_q, int_q;
  logic [LW-1:0] line_q, line_d, line_inc;
  logic [SW-1:0] swp_q, swp_d;
  logic [DW-1:0] raddr_q;
  logic [TW-1:0] cum_q, cum_d, cum_new;
  logic [TW:0]   sum, thr_hi;
  logic          low_found_q, low_found_d, high_found_q, high_found_d;
  logic [DW-1:0] low_tmp_q, low_tmp_d, high_tmp_q, high_tmp_d, nz_tmp_q, nz_tmp_d;
  logic [DW-1:0] low_idx_q, low_idx_d, high_idx_q, high_idx_d;
  logic          vs_rise, din_fall;

  assign vs_rise  = vsync & ~vsync_q;
  assign din_fall = din_valid_q & ~din_valid;
  assign line_inc = line_q + LW'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (vs_rise) state_d = S_ACCUM;
      S_ACCUM: if (din_fall && line_inc == LW'(IH)) state_d = S_SCAN;
      S_SCAN:  if (swp_q == SW'(NB)) state_d = S_CLEAR;
      S_CLEAR: if (swp_q == SW'(NB - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_en   = (state_q == S_ACCUM);
    bin_wr   = (state_q == S_CLEAR);
    busy     = (state_q != S_IDLE);
    host_gnt = (state_q == S_IDLE) && !vs_rise && host_req;
    overrun  = vs_rise && (state_q != S_IDLE);
    bin_addr = '0;
    if (host_gnt) bin_addr = host_addr;
    else if (state_q == S_SCAN || state_q == S_CLEAR) bin_addr = swp_q[DW-1:0];
    host_qv   = host_qv_q;
    host_q    = host_qv_q ? bin_q : '0;
    int_flag  = int_q;
    lowIndex  = low_idx_q;
    highIndex = high_idx_q;
  end

  // Saturating running sum; the high-tail threshold floors at zero if highCnt exceeds the frame.
  assign sum     = {1'b0, cum_q} + {1'b0, bin_q};
  assign cum_new = sum[TW] ? '1 : sum[TW-1:0];
  assign thr_hi  = (TOTAL > {1'b0, highCnt}) ? TOTAL - {1'b0, highCnt} : '0;

  always_comb begin
    line_d       = line_q;
    swp_d        = '0;
    cum_d        = cum_q;
    low_found_d  = low_found_q;
    high_found_d = high_found_q;
    low_tmp_d    = low_tmp_q;
    high_tmp_d   = high_tmp_q;
    nz_tmp_d     = nz_tmp_q;
    low_idx_d    = low_idx_q;
    high_idx_d   = high_idx_q;
    case (state_q)
      S_IDLE:  if (vs_rise) line_d = '0;
      S_ACCUM: begin
        if (din_fall) line_d = line_inc;
        cum_d        = '0;
        low_found_d  = 1'b0;
        high_found_d = 1'b0;
        nz_tmp_d     = '0;
      end
      S_SCAN: begin
        swp_d = (swp_q == SW'(NB)) ? '0 : swp_q + SW'(1);
        if (qv_q) begin
          cum_d = cum_new;
          if (!low_found_q && cum_new >= lowCnt) begin
            low_found_d = 1'b1;
            low_tmp_d   = raddr_q;
          end
          if (!high_found_q && {1'b0, cum_new} >= thr_hi) begin
            high_found_d = 1'b1;
            high_tmp_d   = raddr_q;
          end
          if (bin_q != '0) nz_tmp_d = raddr_q;
        end
      end
      S_CLEAR: swp_d = swp_q + SW'(1);
      S_DONE: begin
        low_idx_d  = low_found_q ? low_tmp_q : '0;
        high_idx_d = high_found_q ? high_tmp_q : nz_tmp_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      din_valid_q  <= 1'b0;
      qv_q         <= 1'b0;
      host_qv_q    <= 1'b0;
      int_q        <= 1'b0;
      raddr_q      <= '0;
      line_q       <= '0;
      swp_q        <= '0;
      cum_q        <= '0;
      low_found_q  <= 1'b0;
      high_found_q <= 1'b0;
      low_tmp_q    <= '0;
      high_tmp_q   <= '0;
      nz_tmp_q     <= '0;
      low_idx_q    <= '0;
      high_idx_q   <= '0;
    end else begin
      vsync_q      <= vsync;
      din_valid_q  <= din_valid;
      qv_q         <= (state_q == S_SCAN) && !swp_q[DW];
      host_qv_q    <= host_gnt;
      int_q        <= (state_q == S_DONE);
      raddr_q      <= swp_q[DW-1:0];
      line_q       <= line_d;
      swp_q        <= swp_d;
      cum_q        <= cum_d;
      low_found_q  <= low_found_d;
      high_found_q <= high_found_d;
      low_tmp_q    <= low_tmp_d;
      high_tmp_q   <= high_tmp_d;
      nz_tmp_q     <= nz_tmp_d;
      low_idx_q    <= low_idx_d;
      high_idx_q   <= high_idx_d;
    end
  end

endmodule

// File: tb/tb_hist_sweep_ctrl.sv
// tb/tb_hist_sweep_ctrl.sv - directed frames against a timeline/bin-table model of hist_sweep_ctrl.
module tb_hist_sweep_ctrl;
  localparam int DW = 4, TW = 32, IW = 4, IH = 2;
  localparam int NB = 1 << DW;
  localparam int BIG = 100000000;

  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, din_valid = 1'b0;
  logic [TW-1:0] lowCnt = '0, highCnt = '0, bin_q;
  logic host_req = 1'b0;
  logic [DW-1:0] host_addr = '0;
  logic acc_en, bin_wr, host_gnt, host_qv, busy, overrun, int_flag;
  logic [DW-1:0] bin_addr, lowIndex, highIndex;
  logic [TW-1:0] host_q;

  hist_sweep_ctrl #(.DW(DW), .TW(TW), .IW(IW), .IH(IH)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .din_valid(din_valid),
    .lowCnt(lowCnt), .highCnt(highCnt), .acc_en(acc_en), .bin_addr(bin_addr),
    .bin_wr(bin_wr), .bin_q(bin_q), .host_req(host_req), .host_addr(host_addr),
    .host_gnt(host_gnt), .host_q(host_q), .host_qv(host_qv), .lowIndex(lowIndex),
    .highIndex(highIndex), .busy(busy), .overrun(overrun), .int_flag(int_flag)
  );

  always #5 clk = ~clk;

  // Bench bin RAM: registered read, clear writes from the DUT, preload port from stimulus.
  logic [TW-1:0] ram [NB];
  logic ld_clr = 1'b0, ld_we = 1'b0;
  logic [DW-1:0] ld_a = '0;
  logic [TW-1:0] ld_d = '0;
  always @(posedge clk) begin
    if (ld_clr) for (int i = 0; i < NB; i++) ram[i] <= '0;
    else if (ld_we) ram[ld_a] <= ld_d;
    if (bin_wr) ram[bin_addr] <= '0;
    bin_q <= ram[bin_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline of the expected behaviour, owned by the stimulus process.
  int acc_s = -BIG, scan_s = -BIG, int_s = -BIG, ovr_c = -BIG, gnt_c = -BIG, rst_eff = -BIG;
  int frame_lo = 0, frame_hi = 0, lit_lo = 0, lit_hi = 0;
  logic [DW-1:0] gnt_a = '0;
  logic [TW-1:0] exp_hq = '0;
  logic chk_en = 1'b0, lit_en = 1'b0, clr_chk = 1'b0;

  int n_pass = 0, n_total = 0;
  int cur_lo = 0, cur_hi = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act !== exp) $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_acc, e_busy, e_wr, e_gnt, e_qv;
      int e_addr;
      if (cyc == rst_eff) begin cur_lo = 0; cur_hi = 0; end
      if (cyc == int_s)   begin cur_lo = frame_lo; cur_hi = frame_hi; end
      e_acc  = (cyc >= acc_s) && (cyc < scan_s);
      e_busy = (cyc >= acc_s) && (cyc <= scan_s + 2*NB + 1);
      e_wr   = (cyc >= scan_s + NB + 1) && (cyc <= scan_s + 2*NB);
      e_gnt  = (cyc == gnt_c);
      e_qv   = (cyc == gnt_c + 1);
      chk("acc_en", acc_en, e_acc);
      chk("busy", busy, e_busy);
      chk("bin_wr", bin_wr, e_wr);
      chk("host_gnt", host_gnt, e_gnt);
      chk("host_qv", host_qv, e_qv);
      chk("overrun", overrun, cyc == ovr_c);
      chk("int_flag", int_flag, cyc == int_s);
      chk("lowIndex", lowIndex, cur_lo);
      chk("highIndex", highIndex, cur_hi);
      e_addr = -1;
      if (cyc >= scan_s && cyc < scan_s + NB) e_addr = cyc - scan_s;
      else if (e_wr) e_addr = cyc - scan_s - NB - 1;
      else if (e_gnt) e_addr = gnt_a;
      else if (!e_busy || e_acc) e_addr = 0;
      if (e_addr >= 0) chk("bin_addr", bin_addr, e_addr);
      if (e_qv) begin
        chk("host_q", host_q, exp_hq);
        chk("host_q_lit", host_q, 32'h1234);
      end
      if (lit_en && cyc == int_s) begin
        chk("lowIndex_lit", lowIndex, lit_lo);
        chk("highIndex_lit", highIndex, lit_hi);
      end
      if (clr_chk && cyc == int_s + 1)
        for (int i = 0; i < NB; i++) chk("bin_cleared", ram[i], 0);
    end
  end

  function automatic void model(input longint lc, input longint hc, output int lo, output int hi);
    longint cum = 0, thr;
    bit lf = 0, hf = 0;
    int nz = 0;
    thr = (IW*IH > hc) ? IW*IH - hc : 0;
    lo = 0; hi = 0;
    for (int b = 0; b < NB; b++) begin
      cum += ram[b];
      if (cum > 64'hFFFF_FFFF) cum = 64'hFFFF_FFFF;
      if (ram[b] != 0) nz = b;
      if (!lf && cum >= lc)  begin lo = b; lf = 1; end
      if (!hf && cum >= thr) begin hi = b; hf = 1; end
    end
    if (!lf) lo = 0;
    if (!hf) hi = nz;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input int a0, input int d0, input int a1, input int d1);
    ld_clr = 1'b1; step(); ld_clr = 1'b0;
    ld_we = 1'b1; ld_a = DW'(a0); ld_d = TW'(d0); step();
    ld_a = DW'(a1); ld_d = TW'(d1); step();
    ld_we = 1'b0; step();
  endtask

  task automatic host_read();
    host_req = 1'b1; host_addr = 4'd7;
    gnt_c = cyc; gnt_a = 4'd7; exp_hq = ram[7];
    step(); host_req = 1'b0; step(); step();
  endtask

  task automatic run_frame(input logic hreq, input int ovr_off, input int rst_off,
                           input int lc, input int hc, input int llo, input int lhi);
    lowCnt = TW'(lc); highCnt = TW'(hc);
    lit_lo = llo; lit_hi = lhi;
    lit_en = (rst_off < 0); clr_chk = (rst_off < 0);
    vsync = 1'b1; host_req = hreq; host_addr = 4'd7;
    acc_s = cyc + 1; scan_s = BIG; int_s = BIG;
    step(); vsync = 1'b0; host_req = 1'b0; step(); step();
    for (int l = 0; l < IH; l++) begin
      din_valid = 1'b1; repeat (3) step();
      din_valid = 1'b0;
      if (l == IH - 1) begin
        scan_s = cyc + 1;
        int_s  = scan_s + 2*NB + 2;
        model(lc, hc, frame_lo, frame_hi);
      end
      step();
    end
    for (int k = 0; k < 2*NB + 6; k++) begin
      step();
      vsync = (ovr_off >= 0) && (cyc == scan_s + ovr_off);
      if (vsync) ovr_c = cyc;
      if (rst_off >= 0 && cyc == scan_s + rst_off) rst = 1'b1;
      else if (rst) begin
        rst = 1'b0;
        acc_s = -BIG; scan_s = -BIG; int_s = -BIG; rst_eff = cyc;
      end
    end
    vsync = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;
    repeat (3) step();
    preload(5, 8, 5, 8);
    run_frame(1'b0, -1, -1, 1, 1, 5, 5);
    preload(2, 3, 9, 5);
    run_frame(1'b0, 5, -1, 4, 2, 9, 9);
    preload(3, 8, 3, 8);
    run_frame(1'b0, -1, -1, 100, 0, 0, 3);
    preload(7, 32'h1234, 7, 32'h1234);
    host_read();
    run_frame(1'b1, -1, -1, 1, 1, 7, 7);
    preload(1, 8, 1, 8);
    run_frame(1'b0, -1, NB + 5, 1, 1, 0, 0);
    preload(0, 2, 15, 6);
    run_frame(1'b0, -1, -1, 2, 3, 0, 15);
    repeat (3) step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hist_sweep_ctrl.md
# hist_sweep_ctrl

Frame-level sequencer for the histogram statistics engine. It enables bin accumulation for exactly IH lines after each vsync. It then sweeps every bin once to compute the cumulative count and the linear-stretch low/high indices, sweeps again to clear all bins to zero, and raises a one-cycle interrupt. Between frames it grants the bin read port to a host requester. It sits between the video timing front end and the dual-port bin RAMs, and owns the RAM's port-B address and write-enable.

## Interface
- DW, 8: bin address width; bin count NB = 2^DW
- TW, 32: bin/count data width
- IW, 640: pixels per line
- IH, 512: lines per frame
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vsync  in  1  frame sync; rising edge starts a frame
- din_valid  in  1  pixel-valid strobe; a falling edge marks end of line
- lowCnt  in  TW  low-tail pixel count threshold
- highCnt  in  TW  high-tail pixel count threshold
- acc_en  out  1  histogram engine accumulate enable
- bin_addr  out  DW  bin RAM port-B address
- bin_wr  out  1  port-B write-zero strobe (clear sweep)
- bin_q  in  TW  port-B read data; 1-cycle latency from bin_addr
- host_req  in  1  host bin-read request
- host_addr  in  DW  host bin address
- host_gnt  out  1  host request accepted this cycle
- host_q  out  TW  host read data
- host_qv  out  1  host_q valid
- lowIndex  out  DW  latched low stretch index
- highIndex  out  DW  latched high stretch index
- busy  out  1  state != IDLE
- overrun  out  1  one-cycle pulse when a vsync edge is ignored
- int_flag  out  1  one-cycle end-of-frame-processing pulse

## Operation
- States: IDLE, ACCUM, SCAN, CLEAR, DONE.
- vsync edge detection:
  - Register vsync; vs_rise = vsync & ~vsync_r.
  - vsync_r resets to 0, so vsync held high through reset produces a rise on the first cycle after reset.
- IDLE:
  - On vs_rise: go to ACCUM and clear line_cnt.
  - vs_rise has priority over host_req; host_gnt = 0 in that cycle.
- ACCUM:
  - acc_en = 1.
  - line_cnt increments on each din_valid falling edge (din_valid_r & ~din_valid).
  - When the increment makes line_cnt == IH: acc_en drops the next cycle and the state goes to SCAN.
- SCAN:
  - bin_addr steps 0..NB-1, one address per cycle.
  - A 1-cycle-delayed qv tags each bin_q.
  - cum (TW bits) += bin_q on each qv, saturating at all-ones. cum is cleared on SCAN entry.
  - Low index: on the first qv where cum_new >= lowCnt, record the bin as low_tmp.
  - High index: on the first qv where cum_new >= IW*IH − highCnt, record the bin as high_tmp.
  - Last nonzero bin: nz_tmp tracks the last bin with bin_q != 0.
  - SCAN lasts NB+1 cycles; the extra cycle drains the read pipeline.
- CLEAR:
  - bin_addr steps 0..NB-1 with bin_wr = 1; NB cycles.
- DONE (1 cycle):
  - lowIndex = low_tmp if found, else 0.
  - highIndex = high_tmp if found, else nz_tmp.
  - Then return to IDLE.
- vs_rise in ACCUM, SCAN, CLEAR or DONE: ignored (no restart) and overrun pulses.
- Host port:
  - Only in IDLE without vs_rise: host_gnt = host_req, and bin_addr = host_addr.
  - host_q = bin_q and host_qv = 1 one cycle after the grant.
  - Outside IDLE, host_gnt = 0 and the host must hold its request.
- Reset mid-operation:
  - Returns to IDLE immediately; cum, line_cnt and the found flags clear.
  - lowIndex/highIndex go to 0.
  - Bins are not cleared; software must re-run a frame.

## Timing
- Reset values:
  - acc_en, bin_wr, host_gnt, host_qv, busy, overrun, int_flag: 0.
  - bin_addr, lowIndex, highIndex, host_q: 0.
- acc_en rises the cycle after vs_rise.
- SCAN entry is the cycle after the IH-th din_valid falling edge.
- int_flag is high in the cycle after DONE, i.e. 2·NB+2 cycles after SCAN entry. lowIndex/highIndex are already updated in that cycle.
- Host read latency: 1 cycle (grant → host_qv).
- bin_wr and host_gnt are never high in the same cycle.
- acc_en and bin_addr sweeps never overlap.

## Test plan
- DW=4, IW=4, IH=2; bench RAM with bin[5]=8; lowCnt=1, highCnt=1 → lowIndex=5, highIndex=5. int_flag 34 cycles after SCAN entry. All 16 bins read 0 afterward.
- Bins[2]=3, [9]=5; lowCnt=4, highCnt=2 (threshold 6) → lowIndex=9 (cum reaches 3 at bin 2, 8 at bin 9), highIndex=9.
- lowCnt=100 and highCnt=0 with total 8, bins[3]=8 → lowIndex=0, highIndex=3 (threshold 8 is reached at bin 3).
- vsync pulse during SCAN → overrun pulses once, sweep timing unchanged, one int_flag only.
- host_req in IDLE with addr=7, bin[7]=0x1234 → host_gnt that cycle, host_q=0x1234 with host_qv next cycle. vsync rise coincident with host_req → host_gnt=0, state ACCUM.
- rst asserted mid-CLEAR → next cycle busy=0, bin_wr=0, lowIndex=highIndex=0; next frame runs normally.
